// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide: 1 bit per cycle, result XLEN+2 edges after accept (div-by-zero/overflow on the accept edge).
// Holds the result in DONE until out_ready; a new request may be taken on the same edge as the output handshake.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    state_t            state;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   hi, lo, dvs, res_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, ovf, neg_d;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fix_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        in_ready  = reset & ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
        accept    = in_valid & in_ready;
        is_div    = in_op[2];
        a_signed  = (in_op != 3'd3) && (in_op != 3'd5) && (in_op != 3'd7);
        b_signed  = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        a_neg     = a_signed & in_a[XLEN-1];
        b_neg     = b_signed & in_b[XLEN-1];
        mag_a     = a_neg ? (~in_a + 1'b1) : in_a;
        mag_b     = b_neg ? (~in_b + 1'b1) : in_b;
        // remainders follow the dividend; everything else follows sign(a) ^ sign(b)
        neg_d     = (is_div & in_op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div & (in_b == '0);
        ovf       = is_div & ~in_op[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
        fast_res  = '0;
        if (div_zero)
            fast_res = in_op[1] ? in_a : '1;
        else if (ovf)
            fast_res = in_op[1] ? '0 : in_a;

        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? dvs : '0)};
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, dvs};

        prod_s    = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
        case (op_q)
            3'd0:          fix_res = prod_s[XLEN-1:0];
            3'd4, 3'd5:    fix_res = neg_q ? (~lo + 1'b1) : lo;
            3'd6, 3'd7:    fix_res = neg_q ? (~hi + 1'b1) : hi;
            default:       fix_res = prod_s[2*XLEN-1:XLEN];
        endcase

        out_valid = (state == DONE);
        out_data  = out_valid ? res_q : '0;
        out_tag   = out_valid ? tag_q : '0;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= '0;
            tag_q <= '0;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            res_q <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q  <= in_op;
                        tag_q <= in_tag;
                        neg_q <= neg_d;
                        hi    <= '0;
                        lo    <= is_div ? mag_a : mag_b;
                        dvs   <= is_div ? mag_b : mag_a;
                        cnt   <= '0;
                        if (div_zero | ovf) begin
                            res_q <= fast_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (op_q[2]) begin
                            // restoring step: keep the subtraction only if it did not borrow
                            if (!div_diff[XLEN]) begin
                                hi <= div_diff[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= div_shift[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    res_q <= fix_res;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (XLEN=32): results, latency, backpressure, flush and reset.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request, wait for the result, check it, then drain it.
    // Latency is counted in edges after the accept edge (0 = valid straight off the accept edge).
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '1; in_b = '1;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_tag"}, out_tag, tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        int seen;
        int lat;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_tag", out_tag, 5'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 34);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 34);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 34);
        run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34);
        run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34);
        run_op("divu",    3'd5, 32'd100,      32'd7,        5'd9,  32'd14,       34);
        run_op("remu",    3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        34);
        run_op("divu_z",  3'd5, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 0);
        run_op("remu_z",  3'd7, 32'd5,        32'd0,        5'd12, 32'd5,        0);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0,        0);

        // Backpressure, then handshake and new accept on the same edge.
        @(negedge clk);
        in_op = 3'd0; in_a = 32'd6; in_b = 32'd9; in_tag = 5'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_data%0d", i), out_data, 32'd54);
            chk($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd16; in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_out_valid", out_valid, 1'b0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat", lat, 34);
        chk("b2b_data", out_data, 32'd14);
        chk("b2b_tag", out_tag, 5'd16);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Flush in the middle of CALC.
        @(negedge clk);
        in_op = 3'd5; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_result", seen, 0);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd18, 32'd333, 34);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        in_op = 3'd0; in_a = 32'd5; in_b = 32'd5; in_tag = 5'd19; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_out_tag", out_tag, 5'h0);
        chk("arst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("arst_no_result", seen, 0);
        run_op("after_arst", 3'd6, 32'd17, 32'hFFFFFFFB, 5'd20, 32'd2, 34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
